// File: rtl/demux4_pkg.sv
// demux4_pkg: shared constants and types for the 1-to-4 dispatch demultiplexer.
//   CH_NUM   number of output channels
//   SEL_W    width of a channel select
//   ch_sel_t channel index type (used for in_sel, rr_ptr and the decoded target)
package demux4_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    // Round-robin successor; wraps naturally at CH_NUM because CH_NUM == 2**SEL_W.
    function automatic ch_sel_t next_ch(input ch_sel_t cur);
        return cur + ch_sel_t'(1);
    endfunction

endpackage

// File: rtl/demux4_slot.sv
// demux4_slot: one-entry registered slot with valid/ready on both sides.
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake (in_ready = empty or draining this cycle)
//   in_data            beat payload, captured on accept
//   out_valid          slot holds a beat
//   out_ready          consumer takes the held beat this cycle
//   out_data           held beat, stable while out_valid & ~out_ready
module demux4_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic load;

    // Draining and refilling in the same cycle keeps the slot full with no bubble.
    assign in_ready = ~out_valid | out_ready;
    assign load     = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/demux4_dispatch.sv
// demux4_dispatch: steers one valid/ready input stream into one of four
// one-entry output slots, chosen by in_sel or by an internal round-robin pointer.
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    producer handshake; in_ready follows the target slot only
//   in_data              beat payload
//   in_sel               explicit target channel when rr_en = 0
//   rr_en                1: target is rr_ptr, which advances on every accepted beat
//   out_valid/out_ready  per-channel consumer handshake (bit i = channel i)
//   out_data             channel i at [i*DATA_W +: DATA_W]
//   rr_ptr               current round-robin pointer
module demux4_dispatch
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     rr_en,
    output logic [CH_NUM-1:0]        out_valid,
    input  logic [CH_NUM-1:0]        out_ready,
    output logic [CH_NUM*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]         rr_ptr
);

    ch_sel_t             tgt;
    logic [CH_NUM-1:0]   slot_ready;
    logic [CH_NUM-1:0]   slot_valid_in;
    logic                accept;

    assign tgt      = rr_en ? rr_ptr : in_sel;
    assign in_ready = slot_ready[tgt];
    assign accept   = in_valid & in_ready;

    // Only the targeted slot sees in_valid; the others keep draining independently.
    for (genvar i = 0; i < CH_NUM; i++) begin : g_slot
        assign slot_valid_in[i] = in_valid & (tgt == ch_sel_t'(i));

        demux4_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (slot_valid_in[i]),
            .in_ready  (slot_ready[i]),
            .in_data   (in_data),
            .out_valid (out_valid[i]),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i*DATA_W +: DATA_W])
        );
    end

    // Strict order: a full target blocks the producer rather than skipping ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept && rr_en) begin
            rr_ptr <= next_ch(rr_ptr);
        end
    end

endmodule

// File: tb/tb_demux4_dispatch.sv
// tb_demux4_dispatch: directed bench for demux4_dispatch with a per-channel
// expected-data scoreboard and a small occupancy / round-robin reference model.
module tb_demux4_dispatch;

    localparam int DW = 8;
    localparam int CH = 4;

    typedef logic [DW-1:0] beat_q_t[$];

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic            rr_en;
    logic [CH-1:0]   out_valid;
    logic [CH-1:0]   out_ready;
    logic [CH*DW-1:0] out_data;
    logic [1:0]      rr_ptr;

    int total;
    int bad;

    beat_q_t       exp_q[CH];
    logic [CH-1:0] m_valid;
    logic [1:0]    m_rr;

    demux4_dispatch #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .rr_en     (rr_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered just after a negedge with inputs already driven.
    // Checks handshake/outputs against the model, pops drained beats, pushes accepted ones.
    task automatic cycle(output bit acc);
        logic [1:0]    t;
        bit            er;
        logic [CH-1:0] nv;
        #1;
        t  = rr_en ? m_rr : in_sel;
        er = !m_valid[t] || out_ready[t];
        check("in_ready", {31'd0, in_ready}, {31'd0, er});
        check("out_valid", {28'd0, out_valid}, {28'd0, m_valid});
        for (int i = 0; i < CH; i++) begin
            if (m_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("scoreboard_underflow", 32'(i), 32'hFFFF_FFFF);
                end else begin
                    check($sformatf("out_data_ch%0d", i),
                          {24'd0, out_data[i*DW +: DW]}, {24'd0, exp_q[i][0]});
                    if (out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
        end
        acc = in_valid && er;
        if (acc) exp_q[t].push_back(in_data);
        for (int i = 0; i < CH; i++)
            nv[i] = (acc && (t == 2'(i))) || (m_valid[i] && !out_ready[i]);
        @(posedge clk);
        m_valid = nv;
        if (acc && rr_en) m_rr = m_rr + 2'd1;
        @(negedge clk);
        check("rr_ptr", {30'd0, rr_ptr}, {30'd0, m_rr});
    endtask

    task automatic send(input logic [1:0] sel, input logic [DW-1:0] data);
        bit acc;
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        for (int k = 0; k < 20 && !done; k++) begin
            cycle(acc);
            if (acc) done = 1'b1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle(acc);
    endtask

    initial begin
        bit acc;
        total     = 0;
        bad       = 0;
        m_valid   = '0;
        m_rr      = '0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        rr_en     = 1'b0;
        out_ready = '0;

        // Reset state
        #3;
        check("rst_out_valid", {28'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Direct steer to channel c
        out_ready = 4'hF;
        send(2'd2, 8'hA5);
        check("steer_valid", {28'd0, out_valid}, 32'h4);
        check("steer_data", {24'd0, out_data[2*DW +: DW]}, 32'hA5);
        idle(2);

        // Back-pressure on channel b
        out_ready = 4'b1101;
        send(2'd1, 8'h11);
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 8'h22;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("bp_hold_data", {24'd0, out_data[1*DW +: DW]}, 32'h11);
            @(negedge clk);
        end
        out_ready = 4'hF;
        send(2'd1, 8'h22);
        check("bp_no_bubble_valid", {31'd0, out_valid[1]}, 32'd1);
        check("bp_no_bubble_data", {24'd0, out_data[1*DW +: DW]}, 32'h22);
        idle(2);

        // Round-robin: five beats land on 0,1,2,3,0; in_sel is ignored
        rr_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            send(2'(5 - k), 8'(k));
            check("rr_channel", {28'd0, out_valid}, 32'(1 << ((k - 1) % 4)));
        end
        check("rr_wrap_ptr", {30'd0, rr_ptr}, 32'd1);
        idle(2);

        // Round-robin stall on a full channel 2 with pointer at 2
        rr_en     = 1'b0;
        out_ready = 4'b1011;
        send(2'd2, 8'h33);
        rr_en = 1'b1;
        send(2'd0, 8'h44);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int k = 0; k < 3; k++) begin
            cycle(acc);
            check("rr_stall_ptr", {30'd0, rr_ptr}, 32'd2);
            check("rr_stall_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 4'hF;
        send(2'd0, 8'h55);
        check("rr_resume_ptr", {30'd0, rr_ptr}, 32'd3);
        check("rr_resume_data", {24'd0, out_data[2*DW +: DW]}, 32'h55);
        idle(2);

        // Reset while channels 0 and 3 hold stalled beats
        rr_en     = 1'b0;
        out_ready = 4'b0110;
        send(2'd0, 8'h66);
        send(2'd3, 8'h77);
        idle(1);
        out_ready = 4'b0000;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {28'd0, out_valid}, 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        for (int i = 0; i < CH; i++) exp_q[i].delete();
        m_valid = '0;
        m_rr    = '0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 4'hF;
        idle(3);
        send(2'd0, 8'h88);
        send(2'd3, 8'h99);
        idle(2);

        for (int i = 0; i < CH; i++)
            check($sformatf("final_queue_ch%0d", i), 32'(exp_q[i].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
